// File: rtl/avl_arbiter.sv
// Two-requester arbiter sharing one DDR3 Avalon-MM local port: round-robin command
// grant, grant lock across write bursts, and in-order routing of read returns.
module avl_arbiter #(
    parameter int ADDR_WIDTH    = 24,
    parameter int DATA_WIDTH    = 64,
    parameter int BE_WIDTH      = 8,
    parameter int SIZE_WIDTH    = 7,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_read_req,
    input  logic                  r0_write_req,
    input  logic                  r0_burstbegin,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [SIZE_WIDTH-1:0] r0_size,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [BE_WIDTH-1:0]   r0_be,
    output logic                  r0_ready,
    output logic                  r0_rdata_valid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_read_req,
    input  logic                  r1_write_req,
    input  logic                  r1_burstbegin,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [SIZE_WIDTH-1:0] r1_size,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [BE_WIDTH-1:0]   r1_be,
    output logic                  r1_ready,
    output logic                  r1_rdata_valid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    input  logic                  avl_ready,
    output logic                  avl_burstbegin,
    output logic                  avl_read_req,
    output logic                  avl_write_req,
    output logic [ADDR_WIDTH-1:0] avl_addr,
    output logic [SIZE_WIDTH-1:0] avl_size,
    output logic [DATA_WIDTH-1:0] avl_wdata,
    output logic [BE_WIDTH-1:0]   avl_be,
    input  logic                  avl_rdata_valid,
    input  logic [DATA_WIDTH-1:0] avl_rdata
);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam logic [SIZE_WIDTH-1:0] ONE = SIZE_WIDTH'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);

    // Handshake: a requester beat transfers on any cycle where its request and
    // rN_ready are both high; the controller side transfers on strobe && avl_ready.
    logic                  r_grant;
    logic                  r_rr_last;
    logic                  r_lock;
    logic                  r_hold;
    logic [SIZE_WIDTH-1:0] r_wr_beats_left;
    logic [SIZE_WIDTH-1:0] r_rd_beat_cnt;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_tag_id   [RD_FIFO_DEPTH];
    logic [SIZE_WIDTH-1:0] r_tag_size [RD_FIFO_DEPTH];

    logic                  w_rr_sel;
    logic                  w_sel;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_bb;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_head_id;
    logic [SIZE_WIDTH-1:0] w_head_size;
    logic                  w_ret;
    logic                  w_pop;
    logic                  w_blocked;
    logic                  w_accept;
    logic                  w_push;

    always_comb begin
        w_rr_sel = 1'b0;
        if (r0_read_req || r0_write_req) begin
            if (r1_read_req || r1_write_req)
                w_rr_sel = ~r_rr_last;
            else
                w_rr_sel = 1'b0;
        end else if (r1_read_req || r1_write_req) begin
            w_rr_sel = 1'b1;
        end
    end

    assign w_sel = (r_lock || r_hold) ? r_grant : w_rr_sel;
    assign w_rd  = w_sel ? r1_read_req   : r0_read_req;
    assign w_wr  = w_sel ? r1_write_req  : r0_write_req;
    assign w_bb  = w_sel ? r1_burstbegin : r0_burstbegin;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                         (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_head_id   = r_tag_id[r_rd_ptr[IDX_W-1:0]];
    assign w_head_size = r_tag_size[r_rd_ptr[IDX_W-1:0]];

    // A return into an empty tag FIFO is a stale beat from before reset: drop it.
    assign w_ret = !reset && avl_rdata_valid && !w_empty;
    assign w_pop = w_ret && ((r_rd_beat_cnt + ONE) == w_head_size);

    // A pop this cycle frees a slot, so a read waiting on a full FIFO goes at once.
    assign w_blocked = w_rd && w_full && !w_pop;

    assign avl_read_req   = !reset && w_rd && !w_blocked;
    assign avl_write_req  = !reset && w_wr;
    assign avl_burstbegin = w_bb && (avl_read_req || avl_write_req);
    assign avl_addr       = w_sel ? r1_addr  : r0_addr;
    assign avl_size       = w_sel ? r1_size  : r0_size;
    assign avl_wdata      = w_sel ? r1_wdata : r0_wdata;
    assign avl_be         = w_sel ? r1_be    : r0_be;

    assign w_accept = avl_ready && (avl_read_req || avl_write_req);
    assign w_push   = w_accept && avl_read_req;

    assign r0_ready = !reset && avl_ready && !w_sel && !w_blocked;
    assign r1_ready = !reset && avl_ready &&  w_sel && !w_blocked;

    assign r0_rdata_valid = w_ret && !w_head_id;
    assign r1_rdata_valid = w_ret &&  w_head_id;
    assign r0_rdata       = avl_rdata;
    assign r1_rdata       = avl_rdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_id[r_wr_ptr[IDX_W-1:0]]   <= w_sel;
            r_tag_size[r_wr_ptr[IDX_W-1:0]] <= avl_size;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant         <= 1'b0;
            r_rr_last       <= 1'b1;
            r_lock          <= 1'b0;
            r_hold          <= 1'b0;
            r_wr_beats_left <= '0;
            r_rd_beat_cnt   <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
        end else begin
            r_grant <= w_sel;
            r_hold  <= (w_rd || w_wr) && !w_accept;
            if (w_accept && avl_burstbegin)
                r_rr_last <= w_sel;
            if (w_accept && avl_write_req) begin
                if (r_lock) begin
                    r_wr_beats_left <= r_wr_beats_left - ONE;
                    if (r_wr_beats_left == ONE)
                        r_lock <= 1'b0;
                end else if (avl_burstbegin && (avl_size > ONE)) begin
                    r_lock          <= 1'b1;
                    r_wr_beats_left <= avl_size - ONE;
                end
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + PTR_ONE;
                r_rd_beat_cnt <= '0;
            end else if (w_ret) begin
                r_rd_beat_cnt <= r_rd_beat_cnt + ONE;
            end
        end
    end
endmodule

// File: tb/tb_avl_arbiter.sv
// Directed bench for avl_arbiter: reset, round-robin, write lock, hold, tag FIFO
// full/pop and read-return routing across a mid-return reset.
module tb_avl_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        r0_read_req, r0_write_req, r0_burstbegin;
    logic [23:0] r0_addr;
    logic [6:0]  r0_size;
    logic [63:0] r0_wdata;
    logic [7:0]  r0_be;
    logic        r0_ready, r0_rdata_valid;
    logic [63:0] r0_rdata;
    logic        r1_read_req, r1_write_req, r1_burstbegin;
    logic [23:0] r1_addr;
    logic [6:0]  r1_size;
    logic [63:0] r1_wdata;
    logic [7:0]  r1_be;
    logic        r1_ready, r1_rdata_valid;
    logic [63:0] r1_rdata;
    logic        avl_ready;
    logic        avl_burstbegin, avl_read_req, avl_write_req;
    logic [23:0] avl_addr;
    logic [6:0]  avl_size;
    logic [63:0] avl_wdata;
    logic [7:0]  avl_be;
    logic        avl_rdata_valid;
    logic [63:0] avl_rdata;

    int n_total = 0;
    int n_bad   = 0;

    avl_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_read_req(r0_read_req), .r0_write_req(r0_write_req), .r0_burstbegin(r0_burstbegin),
        .r0_addr(r0_addr), .r0_size(r0_size), .r0_wdata(r0_wdata), .r0_be(r0_be),
        .r0_ready(r0_ready), .r0_rdata_valid(r0_rdata_valid), .r0_rdata(r0_rdata),
        .r1_read_req(r1_read_req), .r1_write_req(r1_write_req), .r1_burstbegin(r1_burstbegin),
        .r1_addr(r1_addr), .r1_size(r1_size), .r1_wdata(r1_wdata), .r1_be(r1_be),
        .r1_ready(r1_ready), .r1_rdata_valid(r1_rdata_valid), .r1_rdata(r1_rdata),
        .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req),
        .avl_write_req(avl_write_req), .avl_addr(avl_addr), .avl_size(avl_size),
        .avl_wdata(avl_wdata), .avl_be(avl_be),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        r0_read_req = 0; r0_write_req = 0; r0_burstbegin = 0;
        r1_read_req = 0; r1_write_req = 0; r1_burstbegin = 0;
        avl_rdata_valid = 0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic r0_rd(input logic [23:0] a, input logic [6:0] s);
        r0_read_req = 1; r0_burstbegin = 1; r0_addr = a; r0_size = s;
    endtask

    task automatic r1_rd(input logic [23:0] a, input logic [6:0] s);
        r1_read_req = 1; r1_burstbegin = 1; r1_addr = a; r1_size = s;
    endtask

    initial begin
        reset = 1;
        idle_all();
        r0_addr = 0; r0_size = 1; r0_wdata = 0; r0_be = 8'hff;
        r1_addr = 0; r1_size = 1; r1_wdata = 0; r1_be = 8'hff;
        avl_ready = 1; avl_rdata = 0;

        // Reset: strobes and readies masked even with requests and returns present.
        tick();
        r0_rd(24'h000010, 7'd1);
        avl_rdata_valid = 1;
        settle();
        chk("rst_avl_read_req", avl_read_req, 0);
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_r0_rvalid", r0_rdata_valid, 0);
        do_reset();

        // 1: single r0 read size 4, four returns all to r0, then FIFO empty.
        r0_rd(24'h000100, 7'd4);
        settle();
        chk("t1_avl_read_req", avl_read_req, 1);
        chk("t1_avl_addr", avl_addr, 64'h100);
        chk("t1_avl_size", avl_size, 4);
        chk("t1_r0_ready", r0_ready, 1);
        chk("t1_r1_ready", r1_ready, 0);
        tick();
        idle_all();
        for (int k = 0; k < 4; k++) begin
            avl_rdata_valid = 1; avl_rdata = 64'hA000 + 64'(k);
            settle();
            chk("t1_r0_rvalid", r0_rdata_valid, 1);
            chk("t1_r1_rvalid", r1_rdata_valid, 0);
            chk("t1_r0_rdata", r0_rdata, 64'hA000 + 64'(k));
            tick();
        end
        avl_rdata_valid = 1;
        settle();
        chk("t1_empty_r0_rvalid", r0_rdata_valid, 0);
        chk("t1_empty_r1_rvalid", r1_rdata_valid, 0);
        tick();
        avl_rdata_valid = 0;

        // 2: both request continuously; grants alternate starting with r0.
        do_reset();
        r0_rd(24'h000200, 7'd1);
        r1_rd(24'h000300, 7'd1);
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t2_r0_ready", r0_ready, (k % 2 == 0) ? 1 : 0);
            chk("t2_r1_ready", r1_ready, (k % 2 == 0) ? 0 : 1);
            chk("t2_avl_addr", avl_addr, (k % 2 == 0) ? 64'h200 : 64'h300);
            tick();
        end
        idle_all();
        for (int k = 0; k < 6; k++) begin
            avl_rdata_valid = 1;
            settle();
            chk("t2_ret_r0", r0_rdata_valid, (k % 2 == 0) ? 1 : 0);
            chk("t2_ret_r1", r1_rdata_valid, (k % 2 == 0) ? 0 : 1);
            tick();
        end
        avl_rdata_valid = 0;

        // 3: r1 write burst of 3 locks out r0, including across a stall on beat 2.
        do_reset();
        r1_write_req = 1; r1_burstbegin = 1; r1_addr = 24'h000400; r1_size = 3;
        r1_wdata = 64'hB1;
        settle();
        chk("t3_b1_r1_ready", r1_ready, 1);
        chk("t3_b1_avl_write", avl_write_req, 1);
        tick();
        r1_burstbegin = 0; r1_wdata = 64'hB2;
        r0_rd(24'h000500, 7'd1);
        avl_ready = 0;
        settle();
        chk("t3_stall_r0_ready", r0_ready, 0);
        chk("t3_stall_avl_write", avl_write_req, 1);
        chk("t3_stall_avl_read", avl_read_req, 0);
        tick();
        avl_ready = 1;
        settle();
        chk("t3_b2_r1_ready", r1_ready, 1);
        chk("t3_b2_r0_ready", r0_ready, 0);
        tick();
        r1_wdata = 64'hB3;
        settle();
        chk("t3_b3_r1_ready", r1_ready, 1);
        chk("t3_b3_r0_ready", r0_ready, 0);
        chk("t3_b3_wdata", avl_wdata, 64'hB3);
        tick();
        r1_write_req = 0;
        settle();
        chk("t3_after_r0_ready", r0_ready, 1);
        chk("t3_after_avl_addr", avl_addr, 64'h500);
        tick();
        r0_read_req = 0; r0_burstbegin = 0;

        // 4: stalled r0 read holds the port though round-robin would favour r1.
        avl_ready = 0;
        r0_rd(24'h000040, 7'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) r1_rd(24'h000080, 7'd1);
            settle();
            chk("t4_hold_addr", avl_addr, 64'h40);
            chk("t4_hold_r1_ready", r1_ready, 0);
            tick();
        end
        avl_ready = 1;
        settle();
        chk("t4_rise_r0_ready", r0_ready, 1);
        chk("t4_rise_addr", avl_addr, 64'h40);
        tick();
        r0_read_req = 0; r0_burstbegin = 0;
        settle();
        chk("t4_next_r1_ready", r1_ready, 1);
        chk("t4_next_addr", avl_addr, 64'h80);
        tick();
        r1_read_req = 0; r1_burstbegin = 0;

        // 5: eight outstanding reads fill the FIFO; a return frees a slot same cycle.
        do_reset();
        r0_rd(24'h000600, 7'd1);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("t5_fill_r0_ready", r0_ready, 1);
            tick();
        end
        settle();
        chk("t5_full_r0_ready", r0_ready, 0);
        chk("t5_full_avl_read", avl_read_req, 0);
        tick();
        avl_rdata_valid = 1;
        settle();
        chk("t5_pop_r0_rvalid", r0_rdata_valid, 1);
        chk("t5_pop_r0_ready", r0_ready, 1);
        chk("t5_pop_avl_read", avl_read_req, 1);
        tick();
        idle_all();
        settle();
        chk("t5_refull_idle", avl_read_req, 0);

        // 6: r0 size-2 then r1 size-1 route 0,0,1; reset mid-return drops stale beats.
        do_reset();
        r0_rd(24'h000700, 7'd2);
        tick();
        idle_all();
        r1_rd(24'h000800, 7'd1);
        settle();
        chk("t6_r1_ready", r1_ready, 1);
        tick();
        idle_all();
        for (int k = 0; k < 3; k++) begin
            avl_rdata_valid = 1;
            settle();
            chk("t6_ret_r0", r0_rdata_valid, (k < 2) ? 1 : 0);
            chk("t6_ret_r1", r1_rdata_valid, (k < 2) ? 0 : 1);
            tick();
        end
        avl_rdata_valid = 0;
        r0_rd(24'h000900, 7'd2);
        tick();
        idle_all();
        avl_rdata_valid = 1;
        settle();
        chk("t6_mid_r0", r0_rdata_valid, 1);
        tick();
        reset = 1;
        settle();
        chk("t6_rst_r0", r0_rdata_valid, 0);
        chk("t6_rst_r1", r1_rdata_valid, 0);
        tick();
        reset = 0;
        settle();
        chk("t6_stale_r0", r0_rdata_valid, 0);
        chk("t6_stale_r1", r1_rdata_valid, 0);
        tick();
        avl_rdata_valid = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
